svc_rv_mmio_uart_tx: RTL and testbench

Memory-mapped 8N1 UART transmitter with a transmit FIFO. It hangs directly on the RV SoC MMIO port (io_raddr/io_rdata, io_wen/io_waddr/io_wdata/io_wstrb) as a consumer of CPU stores. It is a drop-in peer of the MMIO SRAM, with the same one-cycle registered read latency. Firmware pushes bytes and polls status; the block serializes the bytes on txd.

---
 rtl/svc_rv_uart_pkg.sv | 24 ++
 rtl/svc_rv_mmio_uart_fifo.sv | 68 ++++++
 rtl/svc_rv_mmio_uart_tx.sv | 189 ++++++++++++++++++
 tb/tb_svc_rv_mmio_uart_tx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/svc_rv_uart_pkg.sv
// Shared definitions for the MMIO UART transmitter.
//   - register offsets (word index, addr[3:2])
//   - STATUS register bit positions
//   - transmit FSM state encoding
package svc_rv_uart_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/svc_rv_mmio_uart_fifo.sv
// Synchronous first-word-fall-through FIFO for the UART transmit path.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push/wdata : write request; accepted when not full, or when a pop
//                happens in the same cycle
//   pop/rdata  : rdata always shows the head entry; pop consumes it
//   full/empty/count : occupancy, derived from count
module svc_rv_mmio_uart_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             push_acc;
  logic             pop_acc;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign pop_acc  = pop && !empty;
  // A pop frees the head slot this cycle, so a push into a full FIFO fits.
  assign push_acc = push && (!full || pop_acc);

  always_comb begin
    wr_ptr_d = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_acc  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/svc_rv_mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with transmit FIFO.
//   clk, rst_n          : clock, async active-low reset
//   io_raddr / io_rdata : read port, data registered one cycle after address
//   io_wen, io_waddr, io_wdata, io_wstrb : store port
//   txd                 : serial output, idle high
// Registers (addr[3:2]): 0 TXDATA (W), 1 STATUS (R/W1C), 2 CTRL (R/W), 3 reserved.
//
// state | meaning
// IDLE  | line high, waiting for an enabled, non-empty FIFO
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (high); may pop the next byte on its last cycle
module svc_rv_mmio_uart_tx
  import svc_rv_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] io_raddr,
  output logic [31:0] io_rdata,
  input  logic        io_wen,
  input  logic [31:0] io_waddr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wstrb,
  output logic        txd
);

  localparam int             CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int             BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          ovf_q, ovf_d;
  logic          enable_q, enable_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          wr_hit, rd_hit;
  logic          push_req, w1c_ovf, ctrl_wr;
  logic          pop, pop_ok, baud_zero;
  logic [7:0]    fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status;
  logic          unused_bits;

  assign unused_bits = ^{io_waddr[1:0], io_raddr[1:0], io_wdata[31:8], io_wstrb[3:1]};

  assign wr_hit   = io_wen && (io_waddr[31:4] == BASE_ADDR[31:4]);
  assign rd_hit   = (io_raddr[31:4] == BASE_ADDR[31:4]);
  assign push_req = wr_hit && (io_waddr[3:2] == OFF_TXDATA) && io_wstrb[0];
  assign w1c_ovf  = wr_hit && (io_waddr[3:2] == OFF_STATUS) && io_wstrb[0] && io_wdata[3];
  assign ctrl_wr  = wr_hit && (io_waddr[3:2] == OFF_CTRL)   && io_wstrb[0];

  assign pop_ok    = enable_q && !fifo_empty;
  assign baud_zero = (baud_q == '0);

  svc_rv_mmio_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .wdata (io_wdata[7:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop_ok) begin
          pop     = 1'b1;
          state_d = START;
          baud_d  = BAUD_LAST;
          shift_d = fifo_rdata;
        end
      end
      START: begin
        if (baud_zero) begin
          state_d   = DATA;
          baud_d    = BAUD_LAST;
          bit_idx_d = '0;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      DATA: begin
        if (baud_zero) begin
          baud_d  = BAUD_LAST;
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      STOP: begin
        if (baud_zero) begin
          // Popping here rather than in IDLE gives back-to-back frames.
          if (pop_ok) begin
            pop     = 1'b1;
            state_d = START;
            baud_d  = BAUD_LAST;
            shift_d = fifo_rdata;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // txd is a flop, so derive it from the next state to keep it aligned.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (w1c_ovf) ovf_d = 1'b0;
    // A dropped byte outranks a same-cycle clear.
    if (push_req && fifo_full && !pop) ovf_d = 1'b1;

    enable_d = ctrl_wr ? io_wdata[0] : enable_q;

    status                         = '0;
    status[STAT_BUSY]              = (state_q != IDLE);
    status[STAT_FULL]              = fifo_full;
    status[STAT_EMPTY]             = fifo_empty;
    status[STAT_OVF]               = ovf_q;
    status[STAT_CNT_LSB +: 8]      = 8'(fifo_count);

    rdata_d = '0;
    if (rd_hit) begin
      case (io_raddr[3:2])
        OFF_STATUS: rdata_d = status;
        OFF_CTRL:   rdata_d = {31'b0, enable_q};
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      ovf_q     <= 1'b0;
      enable_q  <= 1'b1;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      ovf_q     <= ovf_d;
      enable_q  <= enable_d;
      rdata_q   <= rdata_d;
    end
  end

  assign txd      = txd_q;
  assign io_rdata = rdata_q;

endmodule

// File: tb/tb_svc_rv_mmio_uart_tx.sv
// Bench for svc_rv_mmio_uart_tx: expected bytes are queued as they are
// written, and a line monitor captures each txd frame and compares the full
// 10-bit waveform against the one built from the queued byte.
module tb_svc_rv_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] io_raddr = '0;
  logic [31:0] io_rdata;
  logic        io_wen = 1'b0;
  logic [31:0] io_waddr = '0;
  logic [31:0] io_wdata = '0;
  logic [3:0]  io_wstrb = '0;
  logic        txd;

  always #5 clk = ~clk;

  svc_rv_mmio_uart_tx #(
    .BASE_ADDR    (32'h0000_0000),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_raddr (io_raddr),
    .io_rdata (io_rdata),
    .io_wen   (io_wen),
    .io_waddr (io_waddr),
    .io_wdata (io_wdata),
    .io_wstrb (io_wstrb),
    .txd      (txd)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] sb[$];
  int         cyc = 0;
  int         frames = 0;
  bit         mon_busy = 1'b0;
  int         start_last = -1;
  int         start_prev = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FRAME-1:0] exp_wave(input logic [7:0] b);
    logic [FRAME-1:0] w;
    for (int c = 0; c < FRAME; c++) begin
      if (c < CPB)          w[c] = 1'b0;
      else if (c < 9 * CPB) w[c] = b[(c - CPB) / CPB];
      else                  w[c] = 1'b1;
    end
    return w;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    io_wen = 1'b1; io_waddr = a; io_wdata = d; io_wstrb = s;
    @(negedge clk);
    io_wen = 1'b0; io_wstrb = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    io_raddr = a;
    @(negedge clk);
    d = io_rdata;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((sb.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (sb.size() == 0 && !mon_busy), 1);
    repeat (3) @(negedge clk);
  endtask

  // Line monitor: a low txd while idle starts a frame; sample FRAME cycles.
  initial begin
    logic [FRAME-1:0] wav;
    logic [7:0]       eb;
    bit               abort;
    forever begin
      @(negedge clk);
      if (rst_n && txd === 1'b0) begin
        mon_busy   = 1'b1;
        abort      = 1'b0;
        start_prev = start_last;
        start_last = cyc;
        wav        = '0;
        wav[0]     = txd;
        for (int c = 1; c < FRAME; c++) begin
          @(negedge clk);
          if (!rst_n) abort = 1'b1;
          wav[c] = txd;
        end
        if (!abort) begin
          frames++;
          chk("frame_expected", (sb.size() != 0), 1);
          if (sb.size() != 0) begin
            eb = sb.pop_front();
            chk($sformatf("frame_%02h", eb), wav, exp_wave(eb));
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          f0;
    int          hi;

    // Reset state
    repeat (3) @(negedge clk);
    chk("txd_in_reset", txd, 1);
    chk("rdata_in_reset", io_rdata, 0);
    rst_n = 1'b1;
    rd(32'h4, d);  chk("status_after_reset", d, 32'h0000_0004);
    rd(32'h8, d);  chk("ctrl_after_reset", d, 32'h1);
    rd(32'h0, d);  chk("txdata_reads_zero", d, 0);
    chk("txd_idle", txd, 1);

    // Single frame 0x55
    sb.push_back(8'h55);
    wr(32'h0, 32'h55, 4'hF);
    rd(32'h4, d);  chk("status_busy_frame", d, 32'h0000_0005);
    wait_drain("drain_55", 200);
    rd(32'h4, d);  chk("status_idle_after_55", d, 32'h0000_0004);

    // Burst of 18 bytes: 1 popped, 16 queued, last dropped
    f0 = frames;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      io_wen = 1'b1; io_waddr = 32'h0; io_wdata = 32'(i); io_wstrb = 4'hF;
      if (i < 17) sb.push_back(8'(i));
    end
    @(negedge clk);
    io_wen = 1'b0; io_wstrb = '0;
    rd(32'h4, d);  chk("status_full_ovf", d, 32'h0000_100B);
    wait_drain("drain_burst", 2000);
    chk("burst_frame_count", frames - f0, 17);
    rd(32'h4, d);  chk("status_ovf_sticky", d, 32'h0000_000C);
    wr(32'h4, 32'h0, 4'hF);
    rd(32'h4, d);  chk("w1c_zero_no_change", d, 32'h0000_000C);
    wr(32'h4, 32'h8, 4'hF);
    rd(32'h4, d);  chk("w1c_clears_ovf", d, 32'h0000_0004);

    // Disabled: bytes queue, line stays idle; enable -> back-to-back frames
    wr(32'h8, 32'h0, 4'hF);
    rd(32'h8, d);  chk("ctrl_disabled", d, 0);
    sb.push_back(8'hA5);
    wr(32'h0, 32'hA5, 4'hF);
    sb.push_back(8'h3C);
    wr(32'h0, 32'h3C, 4'hF);
    hi = 0;
    repeat (50) begin
      @(negedge clk);
      if (txd === 1'b1) hi++;
    end
    chk("disabled_txd_high", hi, 50);
    rd(32'h4, d);  chk("status_two_queued", d, 32'h0000_0200);
    wr(32'h8, 32'h1, 4'hF);
    wait_drain("drain_b2b", 300);
    chk("b2b_gap", start_last - start_prev, FRAME);
    rd(32'h8, d);  chk("ctrl_enabled", d, 1);

    // Ignored writes: no strobe on byte 0, out-of-window address
    f0 = frames;
    wr(32'h0, 32'h77, 4'b1110);
    rd(32'h4, d);  chk("strb_ignored_count", d, 32'h0000_0004);
    wr(32'h10, 32'h66, 4'hF);
    rd(32'h4, d);  chk("oow_write_ignored", d, 32'h0000_0004);
    repeat (FRAME + 5) @(negedge clk);
    chk("no_frames_ignored", frames - f0, 0);

    // Reserved / out-of-window reads
    rd(32'hC, d);  chk("reserved_reads_zero", d, 0);
    rd(32'h14, d); chk("oow_status_reads_zero", d, 0);
    rd(32'h10, d); chk("oow_reads_zero", d, 0);

    // Reset mid-DATA aborts the frame asynchronously
    io_raddr = 32'h4;
    wr(32'h0, 32'hF0, 4'hF);
    repeat (10) @(negedge clk);
    chk("txd_low_pre_reset", txd, 0);
    chk("rdata_busy_pre_reset", io_rdata, 32'h0000_0005);
    #2 rst_n = 1'b0;
    #1;
    chk("txd_async_reset", txd, 1);
    chk("rdata_async_reset", io_rdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd(32'h4, d);  chk("status_after_mid_reset", d, 32'h0000_0004);
    rd(32'h8, d);  chk("ctrl_after_mid_reset", d, 1);
    repeat (FRAME + 5) @(negedge clk);
    chk("txd_idle_end", txd, 1);
    chk("sb_empty_end", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
